flash_erase_sequencer: RTL and testbench
========================================

Name: flash_erase_sequencer

Overview:
- Multi-sector erase sequencer that drives flash_se_ctrl through its key/addr/se_done interface.
- Takes a start address and a sector count, then issues one single-sector erase per 4 KB sector in ascending order.
- Enforces a minimum idle gap between erases and a per-sector timeout.
- Sits between the host/key logic and flash_se_ctrl; flash_se_ctrl owns the SPI pins.

Parameters:
SECTOR_SIZE, 4096, address increment per sector in bytes; power of two.
GAP_CYCLES, 8, system_clk cycles of idle between se_done and the next se_key; at least 1.
TIMEOUT_CYCLES, 50_000_000, maximum cycles waiting for se_done per sector (1 s at 50 MHz).
CNT_W, 16, width of sector_count and sectors_done.

Ports:
system_clk  in  1  system clock, 50 MHz
system_reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
start_addr  in  32  first sector address; low log2(SECTOR_SIZE) bits forced to 0 on latch
sector_count  in  CNT_W  number of sectors to erase; latched with start
abort  in  1  level or pulse; stops issuing new sectors
se_key  out  1  one-cycle trigger to flash_se_ctrl.key
se_addr  out  32  sector address to flash_se_ctrl.addr
se_done  in  1  one-cycle completion pulse from flash_se_ctrl
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse (normal, aborted or timeout)
aborted  out  1  sticky; set if the run ended due to abort; cleared on next accepted start
err_timeout  out  1  sticky; set if se_done never arrived; cleared on next accepted start
sectors_done  out  CNT_W  sectors completed in the current or last run

Behaviour:
- Reset (async, system_reset_n=0) forces:
  - state to IDLE
  - outputs: se_key=0, se_addr=0, busy=0, done=0, aborted=0, err_timeout=0, sectors_done=0
  - internal counters to 0
- States: IDLE, ISSUE, WAIT_DONE, GAP, FINISH.
- IDLE: if start=1, latch the aligned start_addr into se_addr and sector_count into the remaining counter; clear aborted, err_timeout and sectors_done.
  - sector_count=0 -> FINISH (no se_key is issued).
  - Otherwise -> ISSUE.
- ISSUE: se_key=1 for exactly this cycle, busy=1, se_addr stable; -> WAIT_DONE. Clear the timeout counter.
- WAIT_DONE: se_addr held stable; the timeout counter increments every cycle.
  - se_done=1 -> sectors_done+1, remaining-1.
    - remaining becomes 0 -> FINISH.
    - abort seen (latched any time since ISSUE) -> set aborted, FINISH.
    - else se_addr += SECTOR_SIZE (mod 2^32 wrap, no error), -> GAP.
  - Timeout counter reaches TIMEOUT_CYCLES-1 without se_done -> set err_timeout, FINISH.
  - If se_done and the timeout occur in the same cycle, se_done wins.
- GAP: count GAP_CYCLES cycles.
  - abort during GAP -> set aborted, FINISH.
  - Otherwise -> ISSUE.
  - Consecutive se_key pulses are therefore at least GAP_CYCLES+2 cycles after the previous se_done.
- FINISH: done=1 for one cycle, busy=0 in this cycle; -> IDLE. aborted, err_timeout and sectors_done hold until the next accepted start.
- Latency: start sampled at cycle N -> se_key high at cycle N+1.
- Abort never truncates an erase in progress; the current sector always completes or times out.
- start outside IDLE is ignored and not queued.
- se_done outside WAIT_DONE is ignored.
- abort in IDLE is ignored.
- Reset mid-operation returns to IDLE immediately; no done pulse is generated.

Test Plan:
- start_addr=0x0000_1234, sector_count=3 -> se_key pulses with se_addr=0x1000, 0x2000, 0x3000; each pulse ≥10 cycles after the prior se_done; done one cycle after the 3rd se_done; sectors_done=3; busy low in the done cycle.
- sector_count=0 -> no se_key; done exactly 2 cycles after start; sectors_done=0.
- start_addr=0xFFFF_F000, count=2 -> se_addr=0xFFFF_F000, then 0x0000_0000; done; no error.
- count=4, abort pulsed during WAIT_DONE of sector 2 -> sector 2 completes; no 3rd se_key; aborted=1; sectors_done=2; done pulse.
- TIMEOUT_CYCLES=100 override, se_done withheld -> err_timeout=1 and done pulse 100 cycles after se_key; sectors_done=0. A later start clears err_timeout.
- Edge cases:
  - start pulsed while busy -> ignored.
  - Stray se_done in GAP -> ignored.
  - system_reset_n low during WAIT_DONE -> all outputs 0 asynchronously; no done; a new start then works normally.

Source files
------------

// File: rtl/flash_erase_sequencer.sv
// Multi-sector erase sequencer in front of flash_se_ctrl.
// One key/addr per sector, idle gap between sectors, per-sector timeout.
module flash_erase_sequencer #(
  parameter int unsigned SECTOR_SIZE    = 4096,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             system_clk,
  input  logic             system_reset_n,
  input  logic             start,
  input  logic [31:0]      start_addr,
  input  logic [CNT_W-1:0] sector_count,
  input  logic             abort,
  output logic             se_key,
  output logic [31:0]      se_addr,
  input  logic             se_done,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err_timeout,
  output logic [CNT_W-1:0] sectors_done
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  // Fires on the cycle the count would reach TIMEOUT_CYCLES-1.
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES);
  localparam logic [31:0]      ADDR_MASK = ~(32'(SECTOR_SIZE) - 32'd1);
  localparam logic [31:0]      ADDR_INC  = 32'(SECTOR_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_FINISH
  } state_t;

  state_t           r_state;
  logic             r_se_key;
  logic [31:0]      r_se_addr;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic             r_err_timeout;
  logic [CNT_W-1:0] r_sectors_done;
  logic [CNT_W-1:0] r_remaining;
  logic [TO_W-1:0]  r_to_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_abort_seen;

  logic w_abort_any;
  logic w_last;

  assign w_abort_any = abort | r_abort_seen;
  assign w_last      = (r_remaining == CNT_W'(1));

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_state        <= S_IDLE;
      r_se_key       <= 1'b0;
      r_se_addr      <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_aborted      <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_sectors_done <= '0;
      r_remaining    <= '0;
      r_to_cnt       <= '0;
      r_gap_cnt      <= '0;
      r_abort_seen   <= 1'b0;
    end else begin
      r_se_key <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_se_addr      <= start_addr & ADDR_MASK;
            r_remaining    <= sector_count;
            r_aborted      <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_sectors_done <= '0;
            r_abort_seen   <= 1'b0;
            r_busy         <= 1'b1;
            r_se_key       <= (sector_count != '0);
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_to_cnt <= '0;
          if (abort) r_abort_seen <= 1'b1;
          // A zero-length run passes through here without a key.
          if (r_remaining == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) r_abort_seen <= 1'b1;
          if (se_done) begin
            r_sectors_done <= r_sectors_done + CNT_W'(1);
            r_remaining    <= r_remaining - CNT_W'(1);
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else if (w_abort_any) begin
              r_aborted <= 1'b1;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_FINISH;
            end else begin
              r_se_addr <= r_se_addr + ADDR_INC;
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_FINISH;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_GAP: begin
          if (w_abort_any) begin
            r_aborted <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_FINISH;
          end else if (r_gap_cnt == GAP_LAST) begin
            r_se_key <= 1'b1;
            r_state  <= S_ISSUE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign se_key       = r_se_key;
  assign se_addr      = r_se_addr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign err_timeout  = r_err_timeout;
  assign sectors_done = r_sectors_done;

endmodule

// File: tb/tb_flash_erase_sequencer.sv
// Scoreboard bench for flash_erase_sequencer.
// A flash model answers se_key; a monitor pops expected key/done events.
module tb_flash_erase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [15:0] sector_count = '0;
  logic        abort = 1'b0;
  logic        se_done = 1'b0;
  logic        se_key;
  logic [31:0] se_addr;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        err_timeout;
  logic [15:0] sectors_done;

  flash_erase_sequencer #(
    .SECTOR_SIZE   (4096),
    .GAP_CYCLES    (8),
    .TIMEOUT_CYCLES(100),
    .CNT_W         (16)
  ) dut (
    .system_clk    (clk),
    .system_reset_n(rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .sector_count  (sector_count),
    .abort         (abort),
    .se_key        (se_key),
    .se_addr       (se_addr),
    .se_done       (se_done),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .err_timeout   (err_timeout),
    .sectors_done  (sectors_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ref_sel: 0 = accepted start, 1 = last real se_done, 2 = last se_key
  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    int          ref_sel;
    int          delta;
    logic [15:0] sd;
    bit          ab;
    bit          to;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  int sedone_cyc = 0;
  int key_cyc = 0;
  int key_cnt = 0;
  int done_cnt = 0;
  int resp_delay = 4;
  bit withhold = 1'b0;
  bit stray = 1'b0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int ref_cyc(int sel);
    if (sel == 0) return start_cyc;
    if (sel == 1) return sedone_cyc;
    return key_cyc;
  endfunction

  task automatic push_key(logic [31:0] a, int rs, int d);
    exp_t e;
    e = '{1'b0, a, rs, d, 16'd0, 1'b0, 1'b0};
    sb.push_back(e);
  endtask

  task automatic push_done(logic [15:0] sd, bit ab, bit to,
                           int rs, int d);
    exp_t e;
    e = '{1'b1, 32'd0, rs, d, sd, ab, to};
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (se_key) begin
      key_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key: got addr %0h expected none",
                 se_addr);
      end else begin
        e = sb.pop_front();
        chk("key_kind", {31'd0, e.is_done}, 32'd0);
        chk("key_addr", se_addr, e.addr);
        chk("key_busy", {31'd0, busy}, 32'd1);
        chk("key_latency", cyc - ref_cyc(e.ref_sel), e.delta);
      end
      key_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done expected none");
      end else begin
        e = sb.pop_front();
        chk("done_kind", {31'd0, e.is_done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_sectors", {16'd0, sectors_done}, {16'd0, e.sd});
        chk("done_aborted", {31'd0, aborted}, {31'd0, e.ab});
        chk("done_timeout", {31'd0, err_timeout}, {31'd0, e.to});
        chk("done_latency", cyc - ref_cyc(e.ref_sel), e.delta);
      end
    end
  end

  // Flash model: answers each key after resp_delay cycles.
  initial begin : flash
    forever begin
      @(negedge clk);
      if (se_key && !withhold) begin
        repeat (resp_delay) @(posedge clk);
        #1 se_done = 1'b1;
        sedone_cyc = cyc;
        @(posedge clk);
        #1 se_done = 1'b0;
        if (stray) begin
          repeat (2) @(posedge clk);
          #1 se_done = 1'b1;
          @(posedge clk);
          #1 se_done = 1'b0;
        end
      end
    end
  end

  task automatic do_start(logic [31:0] a, logic [15:0] n);
    @(posedge clk);
    #1 start = 1'b1;
    start_addr = a;
    sector_count = n;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(int n0, int budget, string nm);
    for (int i = 0; i < budget && done_cnt == n0; i++)
      @(posedge clk);
    chk(nm, done_cnt, n0 + 1);
  endtask

  task automatic wait_keys(int target, int budget);
    for (int i = 0; i < budget && key_cnt < target; i++)
      @(posedge clk);
    chk("wait_key", {31'd0, key_cnt >= target}, 32'd1);
  endtask

  int n;
  int kb;

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {27'd0, se_key, busy, done, aborted, err_timeout},
        32'd0);
    chk("rst_addr", se_addr, 32'd0);
    chk("rst_sectors", {16'd0, sectors_done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // three sectors, unaligned start, stray se_done, ignored restart
    stray = 1'b1;
    resp_delay = 4;
    push_key(32'h0000_1000, 0, 1);
    push_key(32'h0000_2000, 1, 10);
    push_key(32'h0000_3000, 1, 10);
    push_done(16'd3, 1'b0, 1'b0, 1, 1);
    n = done_cnt;
    kb = key_cnt;
    do_start(32'h0000_1234, 16'd3);
    wait_keys(kb + 1, 20);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    start_addr = 32'h0000_8000;
    sector_count = 16'd7;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, 200, "t1_done");
    repeat (6) @(posedge clk);
    #1 chk("t1_sectors_idle", {16'd0, sectors_done}, 32'd3);
    stray = 1'b0;

    // zero-length run
    push_done(16'd0, 1'b0, 1'b0, 0, 2);
    n = done_cnt;
    do_start(32'h0000_5000, 16'd0);
    wait_done(n, 10, "t2_done");
    repeat (2) @(posedge clk);

    // address wrap
    push_key(32'hFFFF_F000, 0, 1);
    push_key(32'h0000_0000, 1, 10);
    push_done(16'd2, 1'b0, 1'b0, 1, 1);
    n = done_cnt;
    do_start(32'hFFFF_F000, 16'd2);
    wait_done(n, 100, "t3_done");
    repeat (2) @(posedge clk);

    // abort during second sector
    resp_delay = 6;
    push_key(32'h0001_0000, 0, 1);
    push_key(32'h0001_1000, 1, 10);
    push_done(16'd2, 1'b1, 1'b0, 1, 1);
    n = done_cnt;
    kb = key_cnt;
    do_start(32'h0001_0FFF, 16'd4);
    wait_keys(kb + 2, 60);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done(n, 100, "t4_done");
    repeat (3) @(posedge clk);
    #1 chk("t4_aborted_sticky", {31'd0, aborted}, 32'd1);
    chk("t4_sectors_sticky", {16'd0, sectors_done}, 32'd2);

    // timeout: flash never answers
    withhold = 1'b1;
    push_key(32'h0000_2000, 0, 1);
    push_done(16'd0, 1'b0, 1'b1, 2, 100);
    n = done_cnt;
    do_start(32'h0000_2000, 16'd3);
    wait_done(n, 150, "t5_done");
    repeat (2) @(posedge clk);
    #1 chk("t5_timeout_sticky", {31'd0, err_timeout}, 32'd1);

    // next start clears the timeout flag
    withhold = 1'b0;
    resp_delay = 3;
    push_key(32'h0000_7000, 0, 1);
    push_done(16'd1, 1'b0, 1'b0, 1, 1);
    n = done_cnt;
    do_start(32'h0000_7000, 16'd1);
    chk("t6_timeout_cleared", {31'd0, err_timeout}, 32'd0);
    wait_done(n, 50, "t6_done");
    repeat (2) @(posedge clk);

    // reset in the middle of WAIT_DONE
    withhold = 1'b1;
    push_key(32'h0000_4000, 0, 1);
    do_start(32'h0000_4000, 16'd2);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_flags",
        {27'd0, se_key, busy, done, aborted, err_timeout}, 32'd0);
    chk("t7_rst_addr", se_addr, 32'd0);
    chk("t7_rst_sectors", {16'd0, sectors_done}, 32'd0);
    n = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (120) @(posedge clk);
    chk("t7_no_done", done_cnt, n);
    withhold = 1'b0;
    resp_delay = 2;
    push_key(32'h0000_9000, 0, 1);
    push_done(16'd1, 1'b0, 1'b0, 1, 1);
    n = done_cnt;
    do_start(32'h0000_9000, 16'd1);
    wait_done(n, 50, "t7_done");
    repeat (3) @(posedge clk);

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
